// File: rtl/cpu.sv
// Single-cycle 8-bit load/store processor: 16-bit instructions from an internal ROM,
// eight 8-bit registers, 256-byte data RAM, runs until HALT.
`timescale 1ns/100ps

module cpu_rom (
    input  logic [7:0]  addr,
    output logic [15:0] data
);
    logic [15:0] mem [0:255];

    assign data = mem[addr];
endmodule

module cpu_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] ram [0:255];

    assign rdata = ram[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end
endmodule

module cpu (
    input  logic clk,
    input  logic reset,
    output logic cpu_out
);
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  regs_q [8];
    logic [7:0]  regs_d [8];
    logic        halted_q, halted_d;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [7:0]  imm;
    logic [7:0]  ram_rdata;
    logic        ram_we;

    cpu_rom rom (
        .addr (pc_q),
        .data (instr)
    );

    // Reset gates the write so an instruction aborted by reset leaves RAM untouched.
    cpu_ram memory (
        .clk   (clk),
        .we    (ram_we & ~reset),
        .addr  (regs_q[rs]),
        .wdata (regs_q[rd]),
        .rdata (ram_rdata)
    );

    assign op  = instr[15:12];
    assign rd  = instr[11:9];
    assign rs  = instr[8:6];
    assign rt  = instr[5:3];
    assign imm = instr[7:0];

    always_comb begin
        pc_d     = pc_q + 8'd1;
        regs_d   = regs_q;
        halted_d = halted_q;
        ram_we   = 1'b0;
        if (halted_q) begin
            pc_d = pc_q;
        end else begin
            case (op)
                4'h1: regs_d[rd] = imm;
                4'h2: regs_d[rd] = regs_q[rs] + regs_q[rt];
                4'h3: regs_d[rd] = regs_q[rs] - regs_q[rt];
                4'h4: regs_d[rd] = regs_q[rs] & regs_q[rt];
                4'h5: regs_d[rd] = regs_q[rs] | regs_q[rt];
                4'h6: regs_d[rd] = regs_q[rs] ^ regs_q[rt];
                4'h7: regs_d[rd] = regs_q[rd] + imm;
                4'h8: regs_d[rd] = ram_rdata;
                4'h9: ram_we     = 1'b1;
                4'hA: pc_d       = imm;
                4'hB: if (regs_q[rd] == 8'd0) pc_d = imm;
                4'hC: if (regs_q[rd] != 8'd0) pc_d = imm;
                4'hF: begin
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= 8'd0;
            halted_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'd0;
            end
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            regs_q   <= regs_d;
        end
    end

    assign cpu_out = halted_q;
endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed programs plus random programs compared
// against an instruction-level reference model.
`timescale 1ns/100ps

module tb_cpu;
    logic clk;
    logic reset;
    logic cpu_out;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [15:0] m_rom [256];
    logic [7:0]  m_ram [256];
    logic [7:0]  m_r   [8];
    logic [7:0]  m_pc;
    logic        m_halt;

    cpu dut (
        .clk     (clk),
        .reset   (reset),
        .cpu_out (cpu_out)
    );

    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    // Holds reset, loads the program (rest of ROM zeroed), then releases reset at a negedge.
    task automatic load_and_start(input logic [15:0] prog[$]);
        reset = 1'b1;
        for (int i = 0; i < 256; i++) dut.rom.mem[i] = 16'h0000;
        foreach (prog[i]) dut.rom.mem[i] = prog[i];
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] ins;
        int a, b, d;
        if (m_halt) return;
        ins = m_rom[m_pc];
        d = ins[11:9];
        a = ins[8:6];
        b = ins[5:3];
        case (ins[15:12])
            4'h1: m_r[d] = ins[7:0];
            4'h2: m_r[d] = 8'((int'(m_r[a]) + int'(m_r[b])) % 256);
            4'h3: m_r[d] = 8'((int'(m_r[a]) - int'(m_r[b]) + 256) % 256);
            4'h4: m_r[d] = m_r[a] & m_r[b];
            4'h5: m_r[d] = m_r[a] | m_r[b];
            4'h6: m_r[d] = m_r[a] ^ m_r[b];
            4'h7: m_r[d] = 8'((int'(m_r[d]) + int'(ins[7:0])) % 256);
            4'h8: m_r[d] = m_ram[m_r[a]];
            4'h9: m_ram[m_r[a]] = m_r[d];
            default: ;
        endcase
        if (ins[15:12] == 4'hF) m_halt = 1'b1;
        else if (ins[15:12] == 4'hA) m_pc = ins[7:0];
        else if (ins[15:12] == 4'hB && m_r[d] == 0) m_pc = ins[7:0];
        else if (ins[15:12] == 4'hC && m_r[d] != 0) m_pc = ins[7:0];
        else m_pc = 8'((int'(m_pc) + 1) % 256);
    endtask

    task automatic test_reset();
        logic [15:0] prog[$];
        for (int i = 0; i < 16; i++) prog.push_back(enc_i(4'h1, 3'(i % 8), 8'($urandom_range(1, 255))));
        load_and_start(prog);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #0.2;
        n_total++; if (dut.pc_q !== 8'd0) $display("FAIL reset_pc: got %0d want 0", dut.pc_q); else n_pass++;
        n_total++; if (cpu_out !== 1'b0) $display("FAIL reset_out: got %b want 0", cpu_out); else n_pass++;
        @(negedge clk);
        repeat (6) @(negedge clk);
        // mid-run reset: values must clear without a clock edge
        #0.2 reset = 1'b1;
        #0.2;
        n_total++; if (dut.pc_q !== 8'd0) $display("FAIL midrun_pc: got %0d want 0", dut.pc_q); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (dut.regs_q[i] !== 8'd0) $display("FAIL midrun_r%0d: got %0d want 0", i, dut.regs_q[i]);
            else n_pass++;
        end
        n_total++; if (cpu_out !== 1'b0) $display("FAIL midrun_out: got %b want 0", cpu_out); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [15:0] prog[$];
        prog = '{enc_i(4'h1, 3'd1, 8'd200), enc_i(4'h1, 3'd2, 8'd100),
                 enc_r(4'h2, 3'd3, 3'd1, 3'd2), enc_r(4'h3, 3'd4, 3'd2, 3'd1),
                 enc_r(4'h6, 3'd5, 3'd1, 3'd2), enc_i(4'h7, 3'd1, 8'h38)};
        load_and_start(prog);
        repeat (5) @(negedge clk);
        n_total++; if (dut.regs_q[3] !== 8'd44) $display("FAIL alu_add: got %0d want 44", dut.regs_q[3]); else n_pass++;
        n_total++; if (dut.regs_q[4] !== 8'd156) $display("FAIL alu_sub: got %0d want 156", dut.regs_q[4]); else n_pass++;
        n_total++; if (dut.regs_q[5] !== 8'd172) $display("FAIL alu_xor: got %0d want 172", dut.regs_q[5]); else n_pass++;
        @(negedge clk);
        n_total++; if (dut.regs_q[1] !== 8'd0) $display("FAIL alu_addi_wrap: got %0d want 0", dut.regs_q[1]); else n_pass++;
    endtask

    task automatic test_memory();
        logic [15:0] prog[$];
        prog = '{enc_i(4'h1, 3'd0, 8'd0), enc_i(4'h1, 3'd1, 8'h5A),
                 enc_r(4'h9, 3'd1, 3'd0, 3'd0), enc_r(4'h8, 3'd2, 3'd0, 3'd0), 16'hF000};
        dut.memory.ram[0] = 8'h00;
        load_and_start(prog);
        repeat (4) @(negedge clk);
        n_total++; if (cpu_out !== 1'b0) $display("FAIL mem_early_halt: got %b want 0", cpu_out); else n_pass++;
        @(negedge clk);
        n_total++; if (dut.memory.ram[0] !== 8'h5A) $display("FAIL mem_ram0: got %h want 5a", dut.memory.ram[0]); else n_pass++;
        n_total++; if (dut.regs_q[2] !== 8'h5A) $display("FAIL mem_ld: got %h want 5a", dut.regs_q[2]); else n_pass++;
        n_total++; if (cpu_out !== 1'b1) $display("FAIL mem_halt: got %b want 1", cpu_out); else n_pass++;
        n_total++; if (dut.pc_q !== 8'd4) $display("FAIL mem_halt_pc: got %0d want 4", dut.pc_q); else n_pass++;
    endtask

    task automatic test_loop_and_freeze();
        logic [15:0] prog[$];
        prog = '{enc_i(4'h1, 3'd1, 8'd10), enc_i(4'h1, 3'd2, 8'd0), enc_i(4'h1, 3'd3, 8'd0),
                 enc_r(4'h2, 3'd2, 3'd2, 3'd1), enc_i(4'h7, 3'd1, 8'hFF), enc_i(4'hC, 3'd1, 8'd3),
                 enc_r(4'h9, 3'd2, 3'd3, 3'd0), 16'hF000};
        dut.memory.ram[0] = 8'hEE;
        load_and_start(prog);
        repeat (500) @(negedge clk);
        n_total++; if (dut.memory.ram[0] !== 8'd55) $display("FAIL loop_sum: got %0d want 55", dut.memory.ram[0]); else n_pass++;
        n_total++; if (cpu_out !== 1'b1) $display("FAIL loop_halt: got %b want 1", cpu_out); else n_pass++;
        // a store after HALT must never execute
        dut.rom.mem[8] = enc_r(4'h9, 3'd1, 3'd3, 3'd0);
        repeat (100) @(negedge clk);
        n_total++; if (dut.pc_q !== 8'd7) $display("FAIL freeze_pc: got %0d want 7", dut.pc_q); else n_pass++;
        n_total++; if (dut.regs_q[1] !== 8'd0) $display("FAIL freeze_r1: got %0d want 0", dut.regs_q[1]); else n_pass++;
        n_total++; if (dut.regs_q[2] !== 8'd55) $display("FAIL freeze_r2: got %0d want 55", dut.regs_q[2]); else n_pass++;
        n_total++; if (dut.memory.ram[0] !== 8'd55) $display("FAIL freeze_ram: got %0d want 55", dut.memory.ram[0]); else n_pass++;
        n_total++; if (cpu_out !== 1'b1) $display("FAIL freeze_out: got %b want 1", cpu_out); else n_pass++;
    endtask

    task automatic test_branches();
        logic [15:0] prog[$];
        prog = '{enc_i(4'h1, 3'd1, 8'd1), enc_i(4'hB, 3'd1, 8'h10), enc_i(4'h1, 3'd2, 8'd0),
                 enc_i(4'hC, 3'd2, 8'h10), enc_i(4'h1, 3'd3, 8'd7), 16'hF000};
        load_and_start(prog);
        repeat (6) @(negedge clk);
        n_total++; if (dut.pc_q !== 8'd5) $display("FAIL br_fallthru_pc: got %0d want 5", dut.pc_q); else n_pass++;
        n_total++; if (dut.regs_q[3] !== 8'd7) $display("FAIL br_fallthru_r3: got %0d want 7", dut.regs_q[3]); else n_pass++;
        prog = '{enc_i(4'hA, 3'd0, 8'hFF)};
        load_and_start(prog);
        @(negedge clk);
        n_total++; if (dut.pc_q !== 8'hFF) $display("FAIL jmp_ff: got %0d want 255", dut.pc_q); else n_pass++;
        @(negedge clk);
        n_total++; if (dut.pc_q !== 8'd0) $display("FAIL pc_wrap: got %0d want 0", dut.pc_q); else n_pass++;
    endtask

    task automatic test_reset_blocks_store();
        logic [15:0] prog[$];
        prog = '{enc_i(4'h1, 3'd1, 8'hAA), enc_r(4'h9, 3'd1, 3'd0, 3'd0)};
        dut.memory.ram[0] = 8'h11;
        load_and_start(prog);
        repeat (1) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (dut.memory.ram[0] !== 8'h11) $display("FAIL reset_store: got %h want 11", dut.memory.ram[0]); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_random(input int n_cycles);
        int bad;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            m_rom[i] = 16'($urandom);
            if (i >= 48) m_rom[i] = 16'h0000;
            if (m_rom[i][15:12] >= 4'hA && m_rom[i][15:12] <= 4'hC) m_rom[i][7:0] = 8'($urandom_range(0, 47));
            dut.rom.mem[i] = m_rom[i];
            m_ram[i] = 8'($urandom);
            dut.memory.ram[i] = m_ram[i];
        end
        for (int i = 0; i < 8; i++) m_r[i] = 8'd0;
        m_pc = 8'd0;
        m_halt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            model_step();
            if (dut.pc_q !== m_pc) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL rand_pc_trace: %0d cycles differ, want 0", bad); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (dut.regs_q[i] !== m_r[i]) $display("FAIL rand_r%0d: got %h want %h", i, dut.regs_q[i], m_r[i]);
            else n_pass++;
        end
        n_total++; if (cpu_out !== m_halt) $display("FAIL rand_halt: got %b want %b", cpu_out, m_halt); else n_pass++;
        bad = 0;
        for (int i = 0; i < 256; i++) if (dut.memory.ram[i] !== m_ram[i]) bad++;
        n_total++; if (bad != 0) $display("FAIL rand_ram: %0d words differ, want 0", bad); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_alu();
        test_memory();
        test_loop_and_freeze();
        test_branches();
        test_reset_blocks_store();
        for (int k = 0; k < 8; k++) test_random(120);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
